exception_unit: RTL and testbench

//  Memory-stage exception/interrupt arbiter feeding coprocessor0. Collects per-instruction

---
 rtl/exception_unit.sv | 147 ++++++++++++++
 tb/tb_exception_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/exception_unit.sv
// Memory-stage exception/interrupt arbiter: picks one event per retiring instruction,
// drives the CP0 exception/pc inputs and issues a redirect plus a multi-cycle pipeline flush.
module exception_unit #(
  parameter int unsigned          ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] EXC_VECTOR  = 32'h0000_0040,
  parameter logic [ADDR_WIDTH-1:0] BEV_VECTOR  = 32'hBFC0_0380,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_valid,
  input  logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_in_delay,
  input  logic                  pipe_stall,
  input  logic                  exc_syscall,
  input  logic                  exc_illegal,
  input  logic                  exc_trap,
  input  logic                  exc_overflow,
  input  logic                  exc_eret,
  input  logic [5:0]            hardware_int_raw,
  input  logic [31:0]           cp0_status,
  input  logic [31:0]           cp0_cause,
  input  logic [ADDR_WIDTH-1:0] cp0_epc,
  output logic [5:0]            hardware_int,
  output logic [31:0]           exception,
  output logic [ADDR_WIDTH-1:0] exc_pc,
  output logic                  redirect,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  flush,
  output logic                  dbg_state
);

  localparam logic [31:0] EXCEPT_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXCEPT_ILLEGAL   = 32'h0000_000a;
  localparam logic [31:0] EXCEPT_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXCEPT_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXCEPT_ERET      = 32'h0000_000e;

  localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [5:0]              sync1_q, sync2_q;
  logic [31:0]             exception_q, exception_d;
  logic [ADDR_WIDTH-1:0]   exc_pc_q, exc_pc_d;
  logic [ADDR_WIDTH-1:0]   redirect_pc_q, redirect_pc_d;
  logic                    redirect_q, redirect_d;
  logic                    flush_q, flush_d;

  logic                    int_pend;
  logic                    any_exc;
  logic                    take;
  logic [31:0]             win_code;

  // Only IE, EXL, IM, BEV of Status and IP of Cause matter here.
  logic unused_cp0;
  assign unused_cp0 = ^{cp0_status[31:23], cp0_status[21:16], cp0_status[7:2],
                        cp0_cause[31:16], cp0_cause[7:0]};

  assign int_pend = (|(cp0_cause[15:8] & cp0_status[15:8])) & cp0_status[0] & ~cp0_status[1];
  assign any_exc  = exc_syscall | exc_illegal | exc_trap | exc_overflow | exc_eret;
  assign take     = (state_q == IDLE) & inst_valid & ~pipe_stall & (int_pend | any_exc);

  always_comb begin
    win_code = EXCEPT_NONE;
    if (int_pend)          win_code = EXCEPT_INTERRUPT;
    else if (exc_illegal)  win_code = EXCEPT_ILLEGAL;
    else if (exc_overflow) win_code = EXCEPT_OVERFLOW;
    else if (exc_trap)     win_code = EXCEPT_TRAP;
    else if (exc_syscall)  win_code = EXCEPT_SYSCALL;
    else if (exc_eret)     win_code = EXCEPT_ERET;
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    exception_d   = EXCEPT_NONE;
    exc_pc_d      = exc_pc_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    flush_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d     = FLUSH;
          cnt_d       = CNT_W'(FLUSH_CYCLES - 1);
          exception_d = win_code;
          // A delay-slot victim restarts at its branch.
          exc_pc_d    = inst_in_delay ? (inst_pc - ADDR_WIDTH'(4)) : inst_pc;
          redirect_d  = 1'b1;
          if (win_code == EXCEPT_ERET) redirect_pc_d = cp0_epc;
          else                         redirect_pc_d = cp0_status[22] ? BEV_VECTOR : EXC_VECTOR;
          flush_d     = 1'b1;
        end
      end
      FLUSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
          flush_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sync1_q       <= '0;
      sync2_q       <= '0;
      exception_q   <= EXCEPT_NONE;
      exc_pc_q      <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      flush_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sync1_q       <= hardware_int_raw;
      sync2_q       <= sync1_q;
      exception_q   <= exception_d;
      exc_pc_q      <= exc_pc_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      flush_q       <= flush_d;
    end
  end

  assign hardware_int = sync2_q;
  assign exception    = exception_q;
  assign exc_pc       = exc_pc_q;
  assign redirect     = redirect_q;
  assign redirect_pc  = redirect_pc_q;
  assign flush        = flush_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios plus random exception mixes, with expected
// CP0/redirect values queued at drive time and popped when the redirect strobe appears.
module tb_exception_unit;

  localparam logic [31:0] EXCEPT_NONE      = 32'h0000_0000;
  localparam logic [31:0] EXCEPT_INTERRUPT = 32'h0000_0001;
  localparam logic [31:0] EXCEPT_SYSCALL   = 32'h0000_0008;
  localparam logic [31:0] EXCEPT_ILLEGAL   = 32'h0000_000a;
  localparam logic [31:0] EXCEPT_OVERFLOW  = 32'h0000_000c;
  localparam logic [31:0] EXCEPT_TRAP      = 32'h0000_000d;
  localparam logic [31:0] EXCEPT_ERET      = 32'h0000_000e;
  localparam logic [31:0] EXC_VEC          = 32'h0000_0040;
  localparam logic [31:0] BEV_VEC          = 32'hBFC0_0380;

  // flag vector order: {illegal, overflow, trap, syscall, eret}
  localparam logic [4:0] F_ERET = 5'b00001, F_SYS = 5'b00010, F_TRAP = 5'b00100,
                         F_OVF  = 5'b01000, F_ILL = 5'b10000;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        inst_valid, inst_in_delay, pipe_stall;
  logic [31:0] inst_pc;
  logic        exc_syscall, exc_illegal, exc_trap, exc_overflow, exc_eret;
  logic [5:0]  hardware_int_raw, hardware_int;
  logic [31:0] cp0_status, cp0_cause, cp0_epc;
  logic [31:0] exception, exc_pc, redirect_pc;
  logic        redirect, flush, dbg_state;

  exception_unit dut (
    .clk(clk), .rst_n(rst_n),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_in_delay(inst_in_delay),
    .pipe_stall(pipe_stall),
    .exc_syscall(exc_syscall), .exc_illegal(exc_illegal), .exc_trap(exc_trap),
    .exc_overflow(exc_overflow), .exc_eret(exc_eret),
    .hardware_int_raw(hardware_int_raw),
    .cp0_status(cp0_status), .cp0_cause(cp0_cause), .cp0_epc(cp0_epc),
    .hardware_int(hardware_int), .exception(exception), .exc_pc(exc_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .dbg_state(dbg_state)
  );

  // CP0 Cause.IP model: one more register after the synchroniser
  logic [5:0] ip_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ip_q <= '0;
    else        ip_q <= hardware_int;
  end
  assign cp0_cause = {18'b0, ip_q, 8'b0};

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [95:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_code(input logic ip, input logic [4:0] f);
    if (ip)        return EXCEPT_INTERRUPT;
    if (f[4])      return EXCEPT_ILLEGAL;
    if (f[3])      return EXCEPT_OVERFLOW;
    if (f[2])      return EXCEPT_TRAP;
    if (f[1])      return EXCEPT_SYSCALL;
    if (f[0])      return EXCEPT_ERET;
    return EXCEPT_NONE;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (redirect) begin
        if (exp_q.size() == 0) begin
          check("spurious_redirect", {31'b0, redirect}, 32'd0);
        end else begin
          logic [95:0] e;
          e = exp_q.pop_front();
          check("exception", exception, e[95:64]);
          check("exc_pc", exc_pc, e[63:32]);
          check("redirect_pc", redirect_pc, e[31:0]);
          check("flush_with_redirect", {31'b0, flush}, 32'd1);
        end
      end else begin
        check("exception_idle", exception, EXCEPT_NONE);
      end
    end
  end

  // driver tasks
  task automatic clear_in();
    inst_valid = 1'b0; inst_in_delay = 1'b0; pipe_stall = 1'b0;
    {exc_illegal, exc_overflow, exc_trap, exc_syscall, exc_eret} = 5'b0;
  endtask

  task automatic drive(input logic [31:0] pc, input logic dly, input logic [4:0] f, input logic ip);
    logic [31:0] code;
    logic [31:0] rpc;
    inst_valid = 1'b1; inst_pc = pc; inst_in_delay = dly;
    {exc_illegal, exc_overflow, exc_trap, exc_syscall, exc_eret} = f;
    code = model_code(ip, f);
    if (code == EXCEPT_ERET) rpc = cp0_epc;
    else                     rpc = cp0_status[22] ? BEV_VEC : EXC_VEC;
    if (code != EXCEPT_NONE) exp_q.push_back({code, dly ? pc - 32'd4 : pc, rpc});
  endtask

  task automatic fire(input logic [31:0] pc, input logic dly, input logic [4:0] f, input logic ip);
    @(negedge clk);
    drive(pc, dly, f, ip);
    @(negedge clk);
    clear_in();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    inst_pc = '0; hardware_int_raw = '0; cp0_status = '0; cp0_epc = '0;
    clear_in();
    repeat (2) @(negedge clk);
    check("rst_exception", exception, 32'd0);
    check("rst_exc_pc", exc_pc, 32'd0);
    check("rst_redirect_pc", redirect_pc, 32'd0);
    check("rst_flags", {28'b0, redirect, flush, dbg_state, 1'b0}, 32'd0);
    check("rst_hw_int", {26'b0, hardware_int}, 32'd0);
    rst_n = 1'b1;

    // T1 syscall with flush duration
    @(negedge clk);
    drive(32'h100, 1'b0, F_SYS, 1'b0);
    @(negedge clk);
    clear_in();
    check("t1_flush_c1", {31'b0, flush}, 32'd1);
    check("t1_state_flush", {31'b0, dbg_state}, 32'd1);
    @(negedge clk);
    check("t1_flush_c2", {31'b0, flush}, 32'd1);
    check("t1_redirect_pulse", {31'b0, redirect}, 32'd0);
    @(negedge clk);
    check("t1_flush_end", {31'b0, flush}, 32'd0);
    check("t1_state_idle", {31'b0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);

    // T2 delay slot, priority, pc wrap
    fire(32'h204, 1'b1, F_OVF | F_TRAP, 1'b0);
    fire(32'h0, 1'b1, F_TRAP | F_SYS, 1'b0);

    // T3 interrupt through synchroniser and CP0 model
    cp0_status = 32'h0000_0401;
    @(negedge clk);
    hardware_int_raw = 6'b000100;
    @(negedge clk);
    check("t3_sync_1clk", {26'b0, hardware_int}, 32'd0);
    @(negedge clk);
    check("t3_sync_2clk", {26'b0, hardware_int}, 32'h4);
    repeat (2) @(negedge clk);
    fire(32'h300, 1'b0, F_SYS, 1'b1);
    cp0_status = 32'h0000_0403;
    fire(32'h304, 1'b0, 5'b0, 1'b0);
    check("t3_exl_no_take", {31'b0, flush}, 32'd0);
    fire(32'h308, 1'b0, F_SYS, 1'b0);
    hardware_int_raw = '0;
    cp0_status = '0;
    repeat (4) @(negedge clk);

    // T4 eret and vectors
    cp0_epc = 32'h1234;
    fire(32'h400, 1'b0, F_ERET, 1'b0);
    fire(32'h400, 1'b0, F_ERET | F_ILL, 1'b0);
    cp0_status = 32'h0040_0000;
    fire(32'h400, 1'b0, F_ERET | F_ILL, 1'b0);
    fire(32'h404, 1'b0, F_ERET, 1'b0);
    cp0_status = '0;

    // T5 stall, flags during flush, first idle cycle
    @(negedge clk);
    inst_valid = 1'b1; inst_pc = 32'h500; exc_trap = 1'b1; pipe_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_stall_no_flush", {31'b0, flush}, 32'd0);
    end
    pipe_stall = 1'b0;
    drive(32'h500, 1'b0, F_TRAP, 1'b0);
    @(negedge clk);
    drive(32'h504, 1'b0, F_SYS, 1'b0);
    void'(exp_q.pop_back());
    @(negedge clk);
    @(negedge clk);
    check("t5_flush_done", {31'b0, flush}, 32'd0);
    drive(32'h508, 1'b0, F_ILL, 1'b0);
    @(negedge clk);
    clear_in();
    repeat (3) @(negedge clk);

    // T6 reset during flush
    @(negedge clk);
    drive(32'h600, 1'b0, F_SYS, 1'b0);
    @(negedge clk);
    clear_in();
    check("t6_flush_before", {31'b0, flush}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_flush", {31'b0, flush}, 32'd0);
    check("t6_rst_redirect", {31'b0, redirect}, 32'd0);
    check("t6_rst_exception", exception, 32'd0);
    check("t6_rst_state", {31'b0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    fire(32'h604, 1'b1, F_ILL, 1'b0);

    // random exception mixes
    for (int i = 0; i < 40; i++) begin
      cp0_status = $urandom_range(0, 1) ? 32'h0040_0000 : 32'h0;
      cp0_epc = $urandom & 32'hFFFF_FFFC;
      fire($urandom & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("queue_drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
